// File: rtl/aes_inv_core.sv
// aes_inv_core -- AES-128 inverse cipher (Nk=4, Nb=4, Nr=10).
//
// Purpose: recovers a plaintext block from a cyphertext block under a
// 128-bit key. The full key schedule is expanded first, one round key per
// cycle. The inverse rounds then run sequentially on a single 128-bit state
// register. Byte packing is column-major: [127:120] = S0,0, [127:96] = w[0].
//
// Ports:
//   clk        in   1    system clock, rising edge
//   nreset     in   1    asynchronous active-low reset
//   load       in   1    level; high holds IDLE and tracks the inputs,
//                        the first low cycle starts decryption
//   key        in   128  cipher key
//   cyphertext in   128  block to decrypt
//   done       out  1    high while plaintext is valid
//   plaintext  out  128  decrypted block, zero unless done
module aes_inv_core (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [127:0] key,
    input  logic [127:0] cyphertext,
    output logic         done,
    output logic [127:0] plaintext
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXPAND,
        S_ADD_LAST,
        S_INV_SHIFT,
        S_SUB_WAIT,
        S_INV_SUB,
        S_ADD_KEY,
        S_INV_MIX,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [127:0]        state_reg;
    logic [10:0][127:0]  rk;
    logic [3:0]          round;
    logic [127:0]        sbox_q;
    logic [127:0]        rk_prev;
    logic [127:0]        rk_cur;
    logic [127:0]        rk_next;

    // GF(2^8) arithmetic, modulus x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (2+4+...+128); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    // S-boxes are derived from the field inverse and the affine map
    // rather than stored as tables
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [7:0] b;
        b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = sbox_inv(s[127-8*k -: 8]);
        return o;
    endfunction

    // Byte (r,c) sits at index 4c+r; row r rotates right by r positions
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] prev, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = prev[127:96];
        w1 = prev[95:64];
        w2 = prev[63:32];
        w3 = prev[31:0];
        t  = {sbox_fwd(w3[23:16]), sbox_fwd(w3[15:8]), sbox_fwd(w3[7:0]), sbox_fwd(w3[31:24])}
             ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // During EXPAND round counts 1..10 and selects the key being built;
    // during the inverse rounds it selects the key being added
    always_comb begin
        rk_prev = rk[0];
        rk_cur  = rk[0];
        for (int i = 0; i < 10; i++)
            if (round == 4'(i + 1)) rk_prev = rk[i];
        for (int i = 0; i <= 10; i++)
            if (round == 4'(i)) rk_cur = rk[i];
        rk_next = expand_key(rk_prev, rcon(round));
    end

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next state and Moore outputs; load overrides everything and parks in IDLE
    always_comb begin
        state_next = state;
        done       = 1'b0;
        plaintext  = '0;
        if (load) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      state_next = S_EXPAND;
                S_EXPAND:    state_next = (round == 4'd10) ? S_ADD_LAST : S_EXPAND;
                S_ADD_LAST:  state_next = S_INV_SHIFT;
                S_INV_SHIFT: state_next = S_SUB_WAIT;
                S_SUB_WAIT:  state_next = S_INV_SUB;
                S_INV_SUB:   state_next = S_ADD_KEY;
                S_ADD_KEY:   state_next = (round == 4'd0) ? S_DONE : S_INV_MIX;
                S_INV_MIX:   state_next = S_INV_SHIFT;
                S_DONE:      state_next = S_DONE;
                default:     state_next = S_IDLE;
            endcase
        end
        if (state == S_DONE) begin
            done      = 1'b1;
            plaintext = state_reg;
        end
    end

    // Synchronous inverse S-box bank: result appears one cycle after the
    // state is presented, which is why SUB_WAIT exists
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) sbox_q <= '0;
        else         sbox_q <= inv_sub_bytes(state_reg);
    end

    // Datapath: state, round keys and round counter. While load is high the
    // inputs are captured, so the first low cycle works on the last values seen.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= '0;
            rk        <= '0;
            round     <= 4'd0;
        end else if (load) begin
            state_reg <= cyphertext;
            rk[0]     <= key;
            round     <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    round <= 4'd1;
                end
                S_EXPAND: begin
                    for (int i = 1; i <= 10; i++)
                        if (round == 4'(i)) rk[i] <= rk_next;
                    if (round != 4'd10) round <= round + 4'd1;
                end
                S_ADD_LAST: begin
                    state_reg <= state_reg ^ rk[10];
                    round     <= 4'd9;
                end
                S_INV_SHIFT: begin
                    state_reg <= inv_shift_rows(state_reg);
                end
                S_INV_SUB: begin
                    state_reg <= sbox_q;
                end
                S_ADD_KEY: begin
                    state_reg <= state_reg ^ rk_cur;
                end
                S_INV_MIX: begin
                    state_reg <= inv_mix_columns(state_reg);
                    if (round != 4'd0) round <= round - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_core.sv
// tb_aes_inv_core -- self-checking bench for aes_inv_core.
//
// Expected plaintexts are pushed to a scoreboard queue when a block is
// loaded and popped when done rises. Random loopback blocks come from a
// forward AES-128 model built on a generated S-box table.
module tb_aes_inv_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic         clk;
    logic         nreset;
    logic         load;
    logic [127:0] key;
    logic [127:0] cyphertext;
    logic         done;
    logic [127:0] plaintext;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;
    logic [127:0] sb [$];
    logic [7:0]   sbox_tab [256];

    aes_inv_core dut (
        .clk        (clk),
        .nreset     (nreset),
        .load       (load),
        .key        (key),
        .cyphertext (cyphertext),
        .done       (done),
        .plaintext  (plaintext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] rot8(input logic [7:0] v, input int n);
        logic [15:0] t;
        t = {v, v} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Walks p over powers of 3 and q over powers of 3^-1 together
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [127:0] keyStep(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {sbox_tab[w[3][23:16]], sbox_tab[w[3][15:8]], sbox_tab[w[3][7:0]], sbox_tab[w[3][31:24]]};
        t[31:24] = t[31:24] ^ rc;
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] k, input logic [127:0] pt);
        logic [127:0] s, t, rkey;
        logic [7:0]   rc, a0, a1, a2, a3;
        rkey = k;
        rc   = 8'h01;
        s    = pt ^ rkey;
        for (int r = 1; r <= 10; r++) begin
            rkey = keyStep(rkey, rc);
            rc   = xt(rc);
            for (int b = 0; b < 16; b++) s[127-8*b -: 8] = sbox_tab[s[127-8*b -: 8]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    s[127-8*(4*c+rw) -: 8] = t[127-8*(4*((c+rw)%4)+rw) -: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            s = s ^ rkey;
        end
        return s;
    endfunction

    // ---------------- checking and stimulus tasks ----------------
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Load high for two cycles, then low; the next rising edge is t0
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] exp);
        @(negedge clk);
        key        = k;
        cyphertext = ct;
        load       = 1'b1;
        repeat (2) @(negedge clk);
        load = 1'b0;
        sb.push_back(exp);
    endtask

    // Counts edges after t0 until done, bounded at 200
    task automatic waitForDone(input bit scramble, output int lat);
        lat = 0;
        @(posedge clk);
        #1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (scramble && lat == 1) begin
                key        = {$urandom(), $urandom(), $urandom(), $urandom()};
                cyphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (lat == 30) checkOutput("busy_plaintext_zero", plaintext, 128'h0);
        end
    endtask

    task automatic runAndCheck(input string tag, input bit scramble);
        int           lat;
        logic [127:0] exp;
        waitForDone(scramble, lat);
        checkOutput({tag, "_latency"}, 128'(lat), 128'd60);
        exp = (sb.size() > 0) ? sb.pop_front() : 128'hx;
        checkOutput({tag, "_plaintext"}, plaintext, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        logic [127:0] k, p, c;

        buildSbox();
        nreset     = 1'b0;
        load       = 1'b1;
        key        = '0;
        cyphertext = '0;

        #2;
        checkOutput("reset_done", 128'(done), 128'h0);
        checkOutput("reset_plaintext", plaintext, 128'h0);
        checkOutput("reset_rk10", dut.rk[10], 128'h0);

        @(negedge clk);
        key        = C1_KEY;
        cyphertext = C1_CT;
        nreset     = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("load_held_done", 128'(done), 128'h0);

        $display("[TB] FIPS-197 C.1");
        applyStimulus(C1_KEY, C1_CT, C1_PT);
        runAndCheck("c1", 1'b0);

        $display("[TB] hold after done");
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 50) cyphertext = ~cyphertext;
            checkOutput("hold_done", 128'(done), 128'h1);
            checkOutput("hold_plaintext", plaintext, C1_PT);
        end

        $display("[TB] abort C.1 with App. B");
        applyStimulus(C1_KEY, C1_CT, C1_PT);
        repeat (26) @(posedge clk);
        #1;
        checkOutput("abort_busy_done", 128'(done), 128'h0);
        @(negedge clk);
        key        = B_KEY;
        cyphertext = B_CT;
        load       = 1'b1;
        sb.delete();
        sb.push_back(B_PT);
        @(negedge clk);
        load = 1'b0;
        runAndCheck("appb", 1'b0);
        checkOutput("appb_rk10", dut.rk[10], B_RK10);
        checkOutput("appb_rk1", dut.rk[1], B_RK1);

        $display("[TB] load pulse while done");
        @(negedge clk);
        key        = C1_KEY;
        cyphertext = C1_CT;
        load       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("done_drop", 128'(done), 128'h0);
        @(negedge clk);
        load = 1'b0;
        sb.push_back(C1_PT);
        runAndCheck("restart", 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus(C1_KEY, C1_CT, C1_PT);
        repeat (31) @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        checkOutput("midreset_done", 128'(done), 128'h0);
        checkOutput("midreset_plaintext", plaintext, 128'h0);
        checkOutput("midreset_rk10", dut.rk[10], 128'h0);
        checkOutput("midreset_round", 128'(dut.round), 128'h0);
        sb.delete();
        load = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        applyStimulus(C1_KEY, C1_CT, C1_PT);
        runAndCheck("after_reset", 1'b0);

        $display("[TB] release reset with load low");
        @(posedge clk);
        #1;
        nreset = 1'b0;
        load   = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        waitForDone(1'b0, lat);
        checkOutput("zero_start_latency", 128'(lat), 128'd60);
        checkOutput("zero_start_reencrypt", aesEncrypt(128'h0, plaintext), 128'h0);

        $display("[TB] loopback");
        for (int n = 0; n < 10; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = aesEncrypt(k, p);
            applyStimulus(k, c, p);
            runAndCheck($sformatf("loop%0d", n), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
